verificador_disparo: RTL and testbench

Reader side of the ship register: takes a stored ship (start cell `barco`, size `tipob`) and resolves incoming shots against it. Each shot is scanned segment by segment and produces one of: miss, hit, repeated hit, or hit-and-sunk. The block keeps a per-segment hit bitmap, and when a ship is sunk it pulses `limpiar` so the ship register can be cleared. There is one instance per ship register, sitting between the shot controller and that ship register.

---
 rtl/batalla_pkg.sv | 21 ++
 rtl/verificador_disparo.sv | 125 ++++++++++++
 tb/tb_verificador_disparo.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/batalla_pkg.sv
// Shared definitions for the battleship board logic: board geometry,
// shot-checker FSM states and the shot result record.
package batalla_pkg;

  localparam int NUM_CASILLAS = 25;
  localparam int TAM_MAX      = 5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } estado_t;

  typedef struct packed {
    logic       impacto;
    logic       repetido;
    logic       hundido;
    logic [2:0] segmento;
  } resultado_t;

endpackage

// File: rtl/verificador_disparo.sv
// Resolves shots against one stored ship, one segment per cycle, keeping a
// per-segment hit bitmap and requesting a register clear when the ship sinks.
module verificador_disparo #(
  parameter int NUM_CASILLAS = batalla_pkg::NUM_CASILLAS,
  parameter int TAM_MAX      = batalla_pkg::TAM_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         barco,
  input  logic [2:0]         tipob,
  input  logic               nuevo,
  input  logic               disparo_valid,
  output logic               disparo_ready,
  input  logic [4:0]         disparo_casilla,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_impacto,
  output logic               res_repetido,
  output logic               res_hundido,
  output logic [2:0]         res_segmento,
  output logic [TAM_MAX-1:0] impactos,
  output logic               limpiar
);

  batalla_pkg::estado_t    estado, estado_sig;
  batalla_pkg::resultado_t res, res_sig;
  logic [2:0]              idx, idx_sig;
  logic [4:0]              tiro, tiro_sig;
  logic [TAM_MAX-1:0]      mapa, mapa_sig;
  logic                    limpiar_q, limpiar_sig;
  logic                    barco_valido;
  logic                    tiro_invalido;
  logic [5:0]              suma;
  logic [TAM_MAX-1:0]      bit_idx;

  // True when the bitmap covers every segment of a ship of size tam.
  function automatic logic cubre(input logic [TAM_MAX-1:0] m, input logic [2:0] tam);
    logic [TAM_MAX:0] mascara;
    mascara = ((TAM_MAX+1)'(1) << tam) - (TAM_MAX+1)'(1);
    return (m & mascara[TAM_MAX-1:0]) == mascara[TAM_MAX-1:0];
  endfunction

  assign barco_valido  = (barco != 5'd0) && (tipob != 3'd0) && (int'(tipob) <= TAM_MAX);
  assign tiro_invalido = !barco_valido || (disparo_casilla == 5'd0) ||
                         (int'(disparo_casilla) > NUM_CASILLAS);
  assign suma          = {1'b0, barco} + {3'b000, idx};
  assign bit_idx       = TAM_MAX'(1) << idx;

  always_comb begin
    estado_sig  = estado;
    idx_sig     = idx;
    tiro_sig    = tiro;
    mapa_sig    = mapa;
    res_sig     = res;
    limpiar_sig = 1'b0;
    if (nuevo) begin
      estado_sig = batalla_pkg::IDLE;
      idx_sig    = 3'd0;
      mapa_sig   = '0;
      res_sig    = '0;
    end else begin
      case (estado)
        batalla_pkg::IDLE: begin
          if (disparo_valid) begin
            tiro_sig   = disparo_casilla;
            idx_sig    = 3'd0;
            res_sig    = '0;
            estado_sig = tiro_invalido ? batalla_pkg::RESP : batalla_pkg::SCAN;
          end
        end
        batalla_pkg::SCAN: begin
          if (suma == {1'b0, tiro}) begin
            res_sig.impacto  = 1'b1;
            res_sig.segmento = idx;
            res_sig.repetido = |(mapa & bit_idx);
            mapa_sig         = mapa | bit_idx;
            res_sig.hundido  = barco_valido && cubre(mapa | bit_idx, tipob);
            estado_sig       = batalla_pkg::RESP;
          end else if (({1'b0, idx} + 4'd1) >= {1'b0, tipob}) begin
            // >= rather than == so a ship vanishing mid-scan cannot spin idx forever
            res_sig.hundido = barco_valido && cubre(mapa, tipob);
            estado_sig      = batalla_pkg::RESP;
          end else begin
            idx_sig = idx + 3'd1;
          end
        end
        batalla_pkg::RESP: begin
          if (res_ready) begin
            estado_sig  = batalla_pkg::IDLE;
            limpiar_sig = res.hundido & ~res.repetido;
          end
        end
        default: estado_sig = batalla_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado    <= batalla_pkg::IDLE;
      idx       <= 3'd0;
      tiro      <= 5'd0;
      mapa      <= '0;
      res       <= '0;
      limpiar_q <= 1'b0;
    end else begin
      estado    <= estado_sig;
      idx       <= idx_sig;
      tiro      <= tiro_sig;
      mapa      <= mapa_sig;
      res       <= res_sig;
      limpiar_q <= limpiar_sig;
    end
  end

  assign disparo_ready = (estado == batalla_pkg::IDLE) && !nuevo;
  assign res_valid     = (estado == batalla_pkg::RESP);
  assign res_impacto   = res.impacto;
  assign res_repetido  = res.repetido;
  assign res_hundido   = res.hundido;
  assign res_segmento  = res.segmento;
  assign impactos      = mapa;
  assign limpiar       = limpiar_q;

endmodule

// File: tb/tb_verificador_disparo.sv
// Scoreboard bench for verificador_disparo; a local ship register model loads
// on nuevo and clears on limpiar, as the real register does.
module tb_verificador_disparo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] barco;
  logic [2:0] tipob;
  logic       nuevo = 1'b0;
  logic       disparo_valid = 1'b0;
  logic       disparo_ready;
  logic [4:0] disparo_casilla = 5'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_impacto, res_repetido, res_hundido;
  logic [2:0] res_segmento;
  logic [4:0] impactos;
  logic       limpiar;

  logic [4:0] carga_barco = 5'd0;
  logic [2:0] carga_tipob = 3'd0;
  logic [4:0] mdl_imp = 5'd0;

  typedef struct {
    logic [5:0] res;
    int         lat;
    logic [4:0] imp;
  } esperado_t;

  esperado_t cola[$];
  int total = 0;
  int bad = 0;

  verificador_disparo dut (
    .clk(clk), .rst(rst), .barco(barco), .tipob(tipob), .nuevo(nuevo),
    .disparo_valid(disparo_valid), .disparo_ready(disparo_ready),
    .disparo_casilla(disparo_casilla), .res_valid(res_valid), .res_ready(res_ready),
    .res_impacto(res_impacto), .res_repetido(res_repetido), .res_hundido(res_hundido),
    .res_segmento(res_segmento), .impactos(impactos), .limpiar(limpiar)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      barco <= 5'd0;
      tipob <= 3'd0;
    end else if (nuevo) begin
      barco <= carga_barco;
      tipob <= carga_tipob;
    end else if (limpiar) begin
      barco <= 5'd0;
      tipob <= 3'd0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

  // Behavioural model: walks the ship cells and predicts result, latency and bitmap.
  task automatic modelo(input logic [4:0] c);
    esperado_t e;
    int hit;
    bit ok;
    e.res = 6'd0;
    e.lat = 0;
    hit = -1;
    ok = (barco != 0) && (tipob != 0) && (tipob <= 5) && (c != 0) && (c <= 25);
    if (ok) begin
      for (int i = 0; i < int'(tipob); i++)
        if (int'(barco) + i == int'(c)) hit = i;
      if (hit >= 0) begin
        e.res[5]    = 1'b1;
        e.res[4]    = mdl_imp[hit];
        mdl_imp[hit] = 1'b1;
        e.res[2:0]  = 3'(hit);
        e.lat       = hit + 1;
      end else begin
        e.lat = int'(tipob);
      end
      e.res[3] = 1'b1;
      for (int i = 0; i < int'(tipob); i++)
        if (!mdl_imp[i]) e.res[3] = 1'b0;
    end
    e.imp = mdl_imp;
    cola.push_back(e);
  endtask

  task automatic place_ship(input logic [4:0] b, input logic [2:0] t);
    @(negedge clk);
    carga_barco = b;
    carga_tipob = t;
    nuevo = 1'b1;
    @(negedge clk);
    nuevo = 1'b0;
    mdl_imp = 5'd0;
  endtask

  task automatic disparar(input logic [4:0] c, output int lat);
    @(negedge clk);
    disparo_casilla = c;
    disparo_valid = 1'b1;
    modelo(c);
    @(posedge clk);
    @(negedge clk);
    disparo_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic aceptar(output logic l1, output logic l2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    l1 = limpiar;
    @(negedge clk);
    l2 = limpiar;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #11;
    total++;
    if ({res_valid, limpiar, impactos} !== 7'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%b want=%b", {res_valid, limpiar, impactos}, 7'd0);
    end
    total++;
    if ({res_impacto, res_repetido, res_hundido, res_segmento} !== 6'd0) begin
      bad++;
      $display("[TB] FAIL reset_result got=%b want=%b",
               {res_impacto, res_repetido, res_hundido, res_segmento}, 6'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (disparo_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready got=%b want=1", disparo_ready);
    end
  endtask

  // One shot: compare result, latency and bitmap against the scoreboard, then hand off.
  task automatic test_shot(input string nombre, input logic [4:0] c);
    esperado_t e;
    int lat;
    logic l1, l2;
    disparar(c, lat);
    e = cola.pop_front();
    total++;
    if ({res_impacto, res_repetido, res_hundido, res_segmento, 8'(lat), impactos} !==
        {e.res, 8'(e.lat), e.imp}) begin
      bad++;
      $display("[TB] FAIL %s got res=%b lat=%0d imp=%b want res=%b lat=%0d imp=%b", nombre,
               {res_impacto, res_repetido, res_hundido, res_segmento}, lat, impactos,
               e.res, e.lat, e.imp);
    end
    aceptar(l1, l2);
    total++;
    if ({l1, l2} !== {e.res[3] & ~e.res[4], 1'b0}) begin
      bad++;
      $display("[TB] FAIL %s_limpiar got=%b want=%b", nombre, {l1, l2},
               {e.res[3] & ~e.res[4], 1'b0});
    end
  endtask

  task automatic test_hit;
    place_ship(5'd7, 3'd3);
    test_shot("hit8", 5'd8);
    total++;
    if (impactos !== 5'b00010) begin
      bad++;
      $display("[TB] FAIL hit8_bitmap got=%b want=00010", impactos);
    end
    test_shot("repeat8", 5'd8);
  endtask

  task automatic test_sink;
    test_shot("hit7", 5'd7);
    test_shot("sink9", 5'd9);
    total++;
    if (impactos !== 5'b00111) begin
      bad++;
      $display("[TB] FAIL sink_bitmap got=%b want=00111", impactos);
    end
    test_shot("after_sink7", 5'd7);
  endtask

  task automatic test_miss;
    place_ship(5'd20, 3'd5);
    test_shot("miss3", 5'd3);
    test_shot("offboard26", 5'd26);
    test_shot("hit24", 5'd24);
    place_ship(5'd9, 3'd0);
    test_shot("empty10", 5'd10);
  endtask

  task automatic test_hold;
    esperado_t e;
    int lat;
    logic l1, l2;
    place_ship(5'd4, 3'd2);
    disparar(5'd5, lat);
    e = cola.pop_front();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({res_valid, res_impacto, res_repetido, res_hundido, res_segmento, impactos} !==
          {1'b1, e.res, e.imp}) begin
        bad++;
        $display("[TB] FAIL hold_cycle%0d got=%b want=%b", i,
                 {res_valid, res_impacto, res_repetido, res_hundido, res_segmento, impactos},
                 {1'b1, e.res, e.imp});
      end
      @(negedge clk);
    end
    aceptar(l1, l2);
    total++;
    if ({l1, l2} !== {e.res[3] & ~e.res[4], 1'b0}) begin
      bad++;
      $display("[TB] FAIL hold_limpiar got=%b want=%b", {l1, l2}, {e.res[3] & ~e.res[4], 1'b0});
    end
  endtask

  task automatic test_nuevo_abort;
    logic visto;
    place_ship(5'd10, 3'd5);
    test_shot("hit10", 5'd10);
    @(negedge clk);
    disparo_casilla = 5'd14;
    disparo_valid = 1'b1;
    @(negedge clk);
    disparo_valid = 1'b0;
    @(negedge clk);
    nuevo = 1'b1;
    @(negedge clk);
    nuevo = 1'b0;
    mdl_imp = 5'd0;
    visto = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) visto = 1'b1;
      @(negedge clk);
    end
    total++;
    if ({visto, impactos, disparo_ready} !== {1'b0, 5'd0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL nuevo_abort got valid_seen=%b imp=%b ready=%b want 0 00000 1",
               visto, impactos, disparo_ready);
    end
  endtask

  task automatic test_reset_mid_scan;
    place_ship(5'd1, 3'd5);
    test_shot("hit1", 5'd1);
    @(negedge clk);
    disparo_casilla = 5'd5;
    disparo_valid = 1'b1;
    @(negedge clk);
    disparo_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({res_valid, res_impacto, res_repetido, res_hundido, res_segmento, impactos, limpiar} !==
        13'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_scan got=%b want=%b",
               {res_valid, res_impacto, res_repetido, res_hundido, res_segmento, impactos, limpiar},
               13'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    mdl_imp = 5'd0;
    @(negedge clk);
    total++;
    if ({disparo_ready, res_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL reset_release got ready/valid=%b want=10", {disparo_ready, res_valid});
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_sink();
    test_miss();
    test_hold();
    test_nuevo_abort();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
